// File: rtl/hdmi_video_timing.sv
// Raster timing generator and colour-bar source feeding the three TMDS
// encoders. All outputs are a one-clock registered decode of (h_cnt, v_cnt).

// Per-channel pixel register: blanks outside the active area and picks
// either the bar level or the constant fill colour.
module hdmi_vt_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             pattern_en,
  input  logic             bar_on,
  input  logic [VEC_W-1:0] fill,
  output logic [VEC_W-1:0] d
);

  // Registered channel data; zero whenever the decode is outside the active area
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            d <= '0;
    else if (!act)       d <= '0;
    else if (pattern_en) d <= bar_on ? {VEC_W{1'b1}} : '0;
    else                 d <= fill;
  end

endmodule

module hdmi_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pattern_en,
  input  logic [7:0]  fill_r,
  input  logic [7:0]  fill_g,
  input  logic [7:0]  fill_b,
  output logic        den,
  output logic [1:0]  c_blue,
  output logic [7:0]  d_r,
  output logic [7:0]  d_g,
  output logic [7:0]  d_b,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // 13-bit compare constants so a region edge equal to 4096 still fits
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt, v_cnt;
  logic [12:0] h_ext, v_ext;
  logic        act, hs_on, vs_on;
  logic [6:0]  bar_ge;
  logic [2:0]  bar_idx;

  logic [NUM_LANES-1:0][VEC_W-1:0] fill_vec;
  logic [NUM_LANES-1:0][VEC_W-1:0] d_vec;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Raster counters: h wraps every line, v advances on the h wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign act   = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_on = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_on = (v_ext >= VS_BEG) && (v_ext < VS_END);

  // Bar k starts at ceil(k*H_ACTIVE/8); x >= that is exactly floor(8x/H_ACTIVE) >= k,
  // so the bar index is the height of this thermometer code.
  for (genvar k = 1; k < 8; k++) begin : g_bnd
    localparam logic [12:0] BND = 13'((k * H_ACTIVE + 7) / 8);
    assign bar_ge[k-1] = (h_ext >= BND);
  end

  // Thermometer-to-index: count the boundaries already passed
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 0; k < 7; k++) bar_idx = bar_idx + {2'b00, bar_ge[k]};
  end

  // Timing outputs: registered decode of the current counter pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      den         <= 1'b0;
      c_blue      <= {~VS_POL, ~HS_POL};
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      den         <= act;
      c_blue      <= {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
      pix_x       <= act ? h_cnt : 12'd0;
      pix_y       <= act ? v_cnt : 12'd0;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

  // Lane 2 = red, 1 = green, 0 = blue, matching bar index bit order
  assign fill_vec = {fill_r, fill_g, fill_b};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hdmi_vt_lane #(.VEC_W(VEC_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .act        (act),
      .pattern_en (pattern_en),
      .bar_on     (bar_idx[i]),
      .fill       (fill_vec[i]),
      .d          (d_vec[i])
    );
  end

  assign {d_r, d_g, d_b} = d_vec;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench: a default 640x480 instance (line-level timing, bars, fill)
// and a tiny 7x5 instance (whole-frame hsync/vsync/den), sharing clock,
// reset and pixel-source inputs.
module tb_hdmi_video_timing;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pattern_en = 1'b0;
  logic [7:0] fill_r = 8'h12, fill_g = 8'h34, fill_b = 8'h56;

  logic        den_a, fs_a, den_b, fs_b;
  logic [1:0]  cb_a, cb_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [11:0] px_a, py_a, px_b, py_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hdmi_video_timing u_a (
    .clk(clk), .rst(rst), .pattern_en(pattern_en),
    .fill_r(fill_r), .fill_g(fill_g), .fill_b(fill_b),
    .den(den_a), .c_blue(cb_a), .d_r(r_a), .d_g(g_a), .d_b(b_a),
    .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a)
  );

  hdmi_video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .pattern_en(pattern_en),
    .fill_r(fill_r), .fill_g(fill_g), .fill_b(fill_b),
    .den(den_b), .c_blue(cb_b), .d_r(r_b), .d_g(g_b), .d_b(b_b),
    .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b)
  );

  // Small instance, one full frame: c_blue = {vsync, hsync}, active-high
  logic [1:0] cb_tab [0:34] = '{
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
  // den bit k for output cycle k: columns 0..3 of lines 0 and 1
  logic [34:0] den_tab = 35'h78F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int den_cnt, hs_cnt, hs_first, vs_cnt, fs_a_cnt, fs_b_cnt, bad;
    den_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0;
    fs_a_cnt = 0; fs_b_cnt = 0; bad = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_den_a", 32'(den_a), 32'd0);
    chk("rst_cb_a", 32'(cb_a), 32'h3);
    chk("rst_cb_b", 32'(cb_b), 32'h0);
    chk("rst_rgb_a", 32'({r_a, g_a, b_a}), 32'h0);
    chk("rst_pix_a", 32'({px_a, py_a}), 32'h0);
    chk("rst_fs_a", 32'(fs_a), 32'd0);

    rst = 1'b1;
    for (int k = 0; k <= 3302; k++) begin
      @(negedge clk);
      // Accumulators for the default instance
      if (k < 800) begin
        den_cnt += int'(den_a);
        if (!cb_a[0]) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
      end
      if (!cb_a[1]) vs_cnt++;
      fs_a_cnt += int'(fs_a);
      if (k < 70) fs_b_cnt += int'(fs_b);
      if (k < 1600) begin
        if (den_a) bad += int'({r_a, g_a, b_a} !== 24'h123456);
        else       bad += int'({r_a, g_a, b_a, px_a, py_a} !== 48'h0);
      end
      // Whole-frame table for the small instance
      if (k < 35) begin
        chk($sformatf("b_cb_%0d", k), 32'(cb_b), 32'(cb_tab[k]));
        chk($sformatf("b_den_%0d", k), 32'(den_b), 32'(den_tab[k]));
      end
      case (k)
        0: begin
          chk("a0_den", 32'(den_a), 32'd1);
          chk("a0_fs", 32'(fs_a), 32'd1);
          chk("a0_pix", 32'({px_a, py_a}), 32'h0);
          chk("a0_rgb", 32'({r_a, g_a, b_a}), 32'h123456);
          chk("b0_fs", 32'(fs_b), 32'd1);
        end
        1:    begin chk("a1_fs", 32'(fs_a), 32'd0); chk("a1_px", 32'(px_a), 32'd1); end
        7:    chk("b7_py", 32'(py_b), 32'd1);
        35:   chk("b35_fs", 32'(fs_b), 32'd1);
        639:  begin chk("a639_den", 32'(den_a), 32'd1); chk("a639_px", 32'(px_a), 32'd639); end
        640:  begin chk("a640_den", 32'(den_a), 32'd0); chk("a640_px", 32'(px_a), 32'd0); end
        655:  chk("a655_cb", 32'(cb_a), 32'h3);
        656:  chk("a656_cb", 32'(cb_a), 32'h2);
        751:  chk("a751_cb", 32'(cb_a), 32'h2);
        752:  chk("a752_cb", 32'(cb_a), 32'h3);
        799:  chk("a799_den", 32'(den_a), 32'd0);
        800: begin
          chk("a800_den", 32'(den_a), 32'd1);
          chk("a800_pix", 32'({px_a, py_a}), 32'h000001);
          chk("a800_fs", 32'(fs_a), 32'd0);
        end
        1699: chk("a_fill_pre", 32'({r_a, g_a, b_a}), 32'h123456);
        1700: chk("a_bar_post", 32'({r_a, g_a, b_a}), 32'h0000FF);
        1750: begin chk("b_bar0", 32'({r_b, g_b, b_b}), 32'h000000); chk("b1750_fs", 32'(fs_b), 32'd1); end
        1751: chk("b_bar1", 32'({r_b, g_b, b_b}), 32'h00FF00);
        1752: chk("b_bar2", 32'({r_b, g_b, b_b}), 32'hFF0000);
        1753: chk("b_bar3", 32'({r_b, g_b, b_b}), 32'hFFFF00);
        1754: chk("b_blank", 32'({r_b, g_b, b_b}), 32'h000000);
        2400: chk("bar_x0", 32'({r_a, g_a, b_a}), 32'h000000);
        2479: chk("bar_x79", 32'({r_a, g_a, b_a}), 32'h000000);
        2480: chk("bar_x80", 32'({r_a, g_a, b_a}), 32'h0000FF);
        2559: chk("bar_x159", 32'({r_a, g_a, b_a}), 32'h0000FF);
        2560: chk("bar_x160", 32'({r_a, g_a, b_a}), 32'h00FF00);
        2720: chk("bar_x320", 32'({r_a, g_a, b_a}), 32'hFF0000);
        2959: chk("bar_x559", 32'({r_a, g_a, b_a}), 32'hFFFF00);
        2960: chk("bar_x560", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
        3039: chk("bar_x639", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
        3040: begin chk("bar_blank", 32'({r_a, g_a, b_a}), 32'h0); chk("bar_blank_den", 32'(den_a), 32'd0); end
        3302: begin
          chk("pre_rst_a", 32'({den_a, px_a, py_a}), 32'h1066004);
          chk("pre_rst_cb_b", 32'(cb_b), 32'h1);
        end
        default: ;
      endcase
      if (k == 1699) pattern_en = 1'b1;
    end

    chk("a_line_den", 32'(den_cnt), 32'd640);
    chk("a_hs_width", 32'(hs_cnt), 32'd96);
    chk("a_hs_start", 32'(hs_first), 32'd656);
    chk("a_no_vs", 32'(vs_cnt), 32'd0);
    chk("a_fs_count", 32'(fs_a_cnt), 32'd1);
    chk("b_fs_count", 32'(fs_b_cnt), 32'd2);
    chk("a_fill_gate", 32'(bad), 32'd0);

    // Asynchronous reset mid-frame, between clock edges
    #2 rst = 1'b0;
    #1;
    chk("arst_den_a", 32'(den_a), 32'd0);
    chk("arst_cb_a", 32'(cb_a), 32'h3);
    chk("arst_den_b", 32'(den_b), 32'd0);
    chk("arst_cb_b", 32'(cb_b), 32'h0);
    chk("arst_pix_a", 32'({px_a, py_a}), 32'h0);
    chk("arst_rgb_a", 32'({r_a, g_a, b_a}), 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_fs_a", 32'(fs_a), 32'd1);
    chk("rel_den_a", 32'(den_a), 32'd1);
    chk("rel_pix_a", 32'({px_a, py_a}), 32'h0);
    chk("rel_fs_b", 32'(fs_b), 32'd1);
    chk("rel_cb_b", 32'(cb_b), 32'h0);
    @(negedge clk);
    chk("rel1_fs_a", 32'(fs_a), 32'd0);
    chk("rel1_px_a", 32'(px_a), 32'd1);
    chk("rel1_px_b", 32'(px_b), 32'd1);
    chk("rel1_rgb_b", 32'({r_b, g_b, b_b}), 32'h00FF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
